// File: rtl/bus_pkg.sv
// Shared constants, state encoding and helpers for the requester-side bus arbiter.
package bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    // Address nibble at and above which an access targets video memory/registers.
    localparam logic [3:0] VID_NIB = 4'hE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ACK  = 2'd2
    } bus_state_e;

    function automatic logic is_video_write(
        input logic              rw_i,
        input logic [ADDR_W-1:0] addr_i,
        input logic [3:0]        nib_i
    );
        return rw_i && (addr_i[ADDR_W-1 -: 4] >= nib_i);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of the mask at or after ptr,
// wrapping modulo N.
module rr_pick #(
    parameter int  N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     elig,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic             valid
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            idx = sum[IDX_W-1:0];
            if (!valid && elig[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the CPU-side bus between N requesters, with
// per-owner lock chaining and vsync gating of video-region writes.
module bus_arbiter
    import bus_pkg::ADDR_W;
    import bus_pkg::DATA_W;
    import bus_pkg::bus_state_e;
    import bus_pkg::IDLE;
    import bus_pkg::XFER;
    import bus_pkg::ACK;
    import bus_pkg::is_video_write;
#(
    parameter int         N       = 2,
    parameter logic [3:0] VID_NIB = bus_pkg::VID_NIB
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vsync,
    input  logic [N-1:0]          req,
    input  logic [N-1:0]          lock,
    input  logic [ADDR_W*N-1:0]   m_addr,
    input  logic [DATA_W*N-1:0]   m_wdata,
    input  logic [N-1:0]          m_rw,
    output logic [N-1:0]          gnt,
    output logic [N-1:0]          m_ack,
    output logic [DATA_W-1:0]     m_rdata,
    output logic [ADDR_W-1:0]     addr,
    output logic [DATA_W-1:0]     data,
    output logic                  rw,
    input  logic [DATA_W-1:0]     din
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    bus_state_e        state_q, state_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [N-1:0]      ack_q, ack_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rw_q, rw_d;

    logic [N-1:0]      elig;
    logic [N-1:0]      pick_oh;
    logic              pick_vld;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  sel_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_rw;
    logic [IDX_W-1:0]  ptr_next;

    // Gating is only evaluated when a grant is made; a transfer already on the
    // bus finishes even if vsync drops.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = req[i] &&
                      (vsync || !is_video_write(m_rw[i], m_addr[i*ADDR_W +: ADDR_W], VID_NIB));
        end
    end

    rr_pick #(.N(N)) u_pick (
        .elig   (elig),
        .ptr    (ptr_q),
        .winner (pick_oh),
        .valid  (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_oh[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    // In ACK the only candidate is the current owner re-loading under lock.
    assign sel_idx = (state_q == ACK) ? owner_q : pick_idx;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_rw   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (IDX_W'(i) == sel_idx) begin
                sel_addr = m_addr[i*ADDR_W +: ADDR_W];
                sel_data = m_wdata[i*DATA_W +: DATA_W];
                sel_rw   = m_rw[i];
            end
        end
    end

    assign ptr_next = (owner_q == IDX_W'(N-1)) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        rw_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick_oh;
                    owner_d = pick_idx;
                    addr_d  = sel_addr;
                    data_d  = sel_data;
                    rw_d    = sel_rw;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (!rw_q) begin
                    rdata_d = din;
                end
                ack_d   = gnt_q;
                state_d = ACK;
            end
            ACK: begin
                if (lock[owner_q] && elig[owner_q]) begin
                    addr_d  = sel_addr;
                    data_d  = sel_data;
                    rw_d    = sel_rw;
                    state_d = XFER;
                end else begin
                    ptr_d   = ptr_next;
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            rw_q    <= rw_d;
        end
    end

    assign gnt     = gnt_q;
    assign m_ack   = ack_q;
    assign m_rdata = rdata_q;
    assign addr    = addr_q;
    assign data    = data_q;
    assign rw      = rw_q;

endmodule
